// File: rtl/st2_pipeline_sequencer.sv
// Stage-2 control sequencer: converts hazard-unit decisions into PC/pipeline
// enables and flushes, and sequences exception entry and halt drain.
module st2_pipeline_sequencer #(
  parameter logic [15:0] EXC_VECTOR   = 16'h0100,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             change_pc,
  input  logic             mem_bubble,
  input  logic             pc_bubble,
  input  logic             halt_req,
  input  logic             alu_exception,
  input  logic             illegal_op,
  input  logic [15:0]      ex_pc,
  input  logic [15:0]      ex_error_val,
  input  logic             resume,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [15:0]      epc,
  output logic [15:0]      err_val,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] exc_count,
  output logic             halted,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_EXC    = 3'd1,
    S_DRAIN  = 3'd2,
    S_HALTED = 3'd3
  } state_t;

  // The PC mux lives outside this block; the vector must be half-word aligned.
  if (DRAIN_CYCLES < 1 || DRAIN_CYCLES > 15 || EXC_VECTOR[0]) begin : g_bad_param
    $error("st2_pipeline_sequencer: bad DRAIN_CYCLES or unaligned EXC_VECTOR");
  end

  state_t     cur_state, nxt_state;
  logic [3:0] drain_cnt, drain_nxt;
  logic       halted_nxt;
  logic       capture;
  logic       fault;

  assign fault = alu_exception | illegal_op;
  assign state = cur_state;

  always_comb begin
    nxt_state   = cur_state;
    drain_nxt   = drain_cnt;
    halted_nxt  = halted;
    capture     = 1'b0;
    pc_write    = 1'b0;
    pc_sel      = 2'b00;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;

    case (cur_state)
      S_RUN: begin
        if (fault) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          capture     = 1'b1;
          nxt_state   = S_EXC;
        end else if (halt_req) begin
          ifid_flush = 1'b1;
          drain_nxt  = 4'(DRAIN_CYCLES - 1);
          nxt_state  = S_DRAIN;
        end else if (mem_bubble) begin
          idex_flush = 1'b1;
        end else if (change_pc) begin
          pc_write   = 1'b1;
          pc_sel     = 2'b01;
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end else if (pc_bubble) begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_write   = 1'b1;
          ifid_write = 1'b1;
        end
      end
      S_EXC: begin
        pc_write   = 1'b1;
        pc_sel     = 2'b10;
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        nxt_state  = S_RUN;
      end
      S_DRAIN: begin
        if (fault) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          exmem_flush = 1'b1;
          capture     = 1'b1;
          nxt_state   = S_EXC;
        end else begin
          ifid_flush = 1'b1;
          if (drain_cnt == 4'd0) begin
            nxt_state  = S_HALTED;
            halted_nxt = 1'b1;
          end else begin
            drain_nxt = drain_cnt - 4'd1;
          end
        end
      end
      S_HALTED: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        if (resume) begin
          halted_nxt = 1'b0;
          nxt_state  = S_RUN;
        end
      end
      default: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        nxt_state   = S_RUN;
      end
    endcase

    // Held reset forces a safe, fully flushed pipeline regardless of state.
    if (!rst_n) begin
      pc_write    = 1'b0;
      pc_sel      = 2'b00;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_RUN;
      drain_cnt <= '0;
      halted    <= 1'b0;
      epc       <= '0;
      err_val   <= '0;
      cause     <= 2'b00;
      exc_count <= '0;
    end else begin
      cur_state <= nxt_state;
      drain_cnt <= drain_nxt;
      halted    <= halted_nxt;
      if (capture) begin
        epc     <= ex_pc;
        err_val <= ex_error_val;
        cause   <= {illegal_op, alu_exception};
        if (exc_count != '1) exc_count <= exc_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/st2_pipeline_sequencer.md
Name: st2_pipeline_sequencer

Overview:
- Stage-2 control sequencer that consumes the hazard unit's decisions (ChangePC, MemBubble, PCBubble, Halt, ALU exception, ExPC, ExErrorVal).
- Drives PC and pipeline-register write enables, per-stage flushes and PC-source select.
- Sequences multi-cycle events: exception capture and vectoring, and pipeline drain before halt.
- Holds the architectural exception state: EPC, error value, cause and exception count.

Parameters:
- EXC_VECTOR, 16'h0100, PC loaded on exception entry.
- DRAIN_CYCLES, 3, cycles spent in DRAIN after a halt request (covers the ID/EX, EX/MEM and MEM/WB drain); legal range 1-15.
- CNT_W, 8, width of the exception counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- change_pc  in  1  taken branch/jump from the hazard unit.
- mem_bubble  in  1  load-use stall request.
- pc_bubble  in  1  freeze PC and insert a NOP into IF/ID.
- halt_req  in  1  halt opcode decoded.
- alu_exception  in  1  ALU overflow/exception.
- illegal_op  in  1  undefined opcode.
- ex_pc  in  16  PC of the faulting instruction.
- ex_error_val  in  16  error value reported with the fault.
- resume  in  1  single-cycle pulse; leaves HALTED.
- pc_write  out  1  PC register enable.
- pc_sel  out  2  00 = PC+2, 01 = branch target, 10 = EXC_VECTOR, 11 = unused.
- ifid_write  out  1  IF/ID enable.
- ifid_flush  out  1  IF/ID clear.
- idex_flush  out  1  ID/EX clear.
- exmem_flush  out  1  EX/MEM clear.
- epc  out  16  captured faulting PC.
- err_val  out  16  captured error value.
- cause  out  2  00 = none, 01 = ALU, 10 = illegal opcode, 11 = both.
- exc_count  out  CNT_W  saturating count of exceptions taken.
- halted  out  1  processor halted.
- state  out  3  current FSM state (debug).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Registered values: state = RUN, epc = 0, err_val = 0, cause = 00, exc_count = 0, halted = 0, drain counter = 0.
  - Combinational outputs while reset is held: pc_write = 0, ifid_write = 0, all three flushes = 1, pc_sel = 00.
  - Reset mid-drain or mid-exception abandons the sequence immediately.
- States: RUN = 0, EXC = 1, DRAIN = 2, HALTED = 3. The codes 4-7 are illegal and go to RUN on the next edge.
- RUN outputs are Mealy and decoded in priority order; exactly one row applies:
  1. fault (alu_exception | illegal_op):
     - Outputs this cycle: pc_write = 0, ifid_write = 0, all flushes = 1.
     - At the edge: epc <= ex_pc, err_val <= ex_error_val, cause <= {illegal_op, alu_exception}, exc_count += 1 (saturates at all-ones), next state = EXC.
  2. halt_req: pc_write = 0, ifid_write = 0, ifid_flush = 1. At the edge, drain counter <= DRAIN_CYCLES-1 and next state = DRAIN.
  3. mem_bubble: pc_write = 0, ifid_write = 0, idex_flush = 1. Stays in RUN. A change_pc asserted in the same cycle is ignored this cycle; the hazard unit re-asserts it.
  4. change_pc: pc_write = 1, pc_sel = 01, ifid_write = 1, ifid_flush = 1.
  5. pc_bubble: pc_write = 0, ifid_write = 1, ifid_flush = 1.
  6. otherwise: pc_write = 1, ifid_write = 1, pc_sel = 00, no flushes.
- EXC (exactly 1 cycle): pc_write = 1, pc_sel = 10, ifid_flush = 1, ifid_write = 1. Next state = RUN. Fault inputs are ignored in this cycle.
- DRAIN:
  - Outputs: pc_write = 0, ifid_write = 0, ifid_flush = 1.
  - Each cycle the counter decrements; when it reaches 0, next state = HALTED and halted <= 1.
  - A fault during DRAIN (an older instruction faulting) pre-empts the drain: capture as in RUN row 1, next state = EXC, and halted stays 0.
  - mem_bubble, change_pc and pc_bubble are ignored in DRAIN.
- HALTED:
  - Outputs: pc_write = 0, ifid_write = 0, all flushes = 1, halted = 1. All inputs except resume are ignored.
  - resume: halted <= 0 and next state = RUN. The PC is unchanged, so execution restarts at the instruction after the halt.
- epc, err_val and cause are written only on fault capture and persist otherwise. A new fault overwrites them.
- Halt latency: halt_req seen in RUN at edge N → halted = 1 after edge N + DRAIN_CYCLES.
- Exception latency: fault seen at edge N → pc_sel = 10 with pc_write = 1 during the cycle following edge N.

Test Plan:
- Reset: hold rst_n = 0 with random inputs → pc_write = 0, all flushes = 1, epc = 0, state = 0. Release → normal fetch: pc_write = 1, pc_sel = 00.
- Load-use: mem_bubble = 1 for 1 cycle → pc_write = 0, ifid_write = 0, idex_flush = 1 in that cycle only. Same cycle with change_pc = 1 → pc_sel stays 00.
- Branch: change_pc = 1 → pc_sel = 01, pc_write = 1, ifid_flush = 1. The next cycle with no request returns to pc_sel = 00.
- ALU exception: ex_pc = 16'hFFFF, ex_error_val = 16'h8000, alu_exception = 1 → all flushes = 1, then epc = FFFF, err_val = 8000, cause = 01, exc_count = 1, next cycle pc_sel = 10 with pc_write = 1, then RUN. Repeat 300 times → exc_count saturates at 255.
- Halt: halt_req pulse → DRAIN for exactly 3 cycles, then halted = 1. Inputs ignored while halted. resume pulse → RUN with pc_write = 1.
- Fault during drain: illegal_op = 1 in the second DRAIN cycle → cause = 10, EXC entered, halted never asserts. Also assert rst_n low mid-DRAIN → immediate return to the reset values.
